alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered successor to the single-cycle ALU for the 5-stage CPU. It executes all existing ALU operations plus iterative multiply and divide into HI/LO registers, with HI/LO move operations. A valid/ready input handshake and a valid output pulse let the EX stage stall for multi-cycle operations. The block sits in EX between the operand-forwarding muxes and the EX/MEM pipeline register.

## Interface
- DATA_WIDTH, 32: operand and result width; must be even and ≥ 8.
- SHAMT_W, $clog2(DATA_WIDTH): number of A bits used as the shift amount.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on A/B/ALUop.
- in_ready  out  1  block can accept; high only in IDLE.
- A, B  in  DATA_WIDTH  operands; A supplies the shift amount, B is the shifted value.
- ALUop  in  5  operation code.
- out_valid  out  1  one-cycle pulse: Result and flags are valid.
- Result  out  DATA_WIDTH  registered result; holds until the next completion.
- Overflow, CarryOut, Zero  out  1 each  registered flags.
- hi, lo  out  DATA_WIDTH  architectural HI/LO registers.

## Operation
- Opcodes 0x00–0x0C: AND, OR, ADD, SUB, SLT, SLTU, SLL, SRL, SAL, SRA, LUI, XOR, NOR.
- Existing ALU semantics are kept, with these generalisations:
  - All shifts use A[SHAMT_W-1:0].
  - SAL is identical to SLL.
  - SRA is arithmetic.
  - LUI gives {B[W/2-1:0], W/2 zeros}.
  - ADD/SUB: CarryOut is the raw carry out of the W-bit add of A+B or A+~B+1. Overflow is the signed overflow.
  - AND, OR, ADD, SUB, XOR, NOR: Zero = (Result == 0).
  - All other ops: Zero = 0.
- 0x0D MULT, 0x0E MULTU: {hi, lo} ← 2W-bit product, signed or unsigned.
- 0x0F DIV, 0x10 DIVU: lo ← quotient, hi ← remainder.
  - Signed division truncates toward zero; the remainder takes the sign of A.
  - MIN / -1 gives lo = MIN, hi = 0.
  - Divide by zero gives lo = all ones, hi = A. Flags are not raised.
- 0x11 MFHI: Result ← hi.
- 0x12 MFLO: Result ← lo.
- 0x13 MTHI: hi ← A.
- 0x14 MTLO: lo ← A.
- Opcodes 0x15–0x1F are illegal: Result = 0, all flags 0, HI/LO unchanged.
- After MULT/MULTU/DIV/DIVU: Result = new lo, and all flags are 0.
- After MF/MT ops: all flags are 0.
- The FSM has four states: IDLE, MUL, DIV, FIX.
  - IDLE: in_valid & in_ready = accept. An accepted single-cycle op stays in IDLE. An accepted mult op goes to MUL; an accepted div op goes to DIV.
  - On accept of a mult or div, operands are latched as magnitudes (signed ops) with the sign flags stored, and a counter is loaded with DATA_WIDTH.
  - MUL: one shift-add step per cycle. DIV: one restoring step per cycle. When the counter reaches 0 after W steps → FIX.
  - FIX: sign correction is applied, then hi/lo/Result are written → IDLE.
- in_valid is ignored while not in IDLE. No operation is ever queued.

## Timing
- Reset values: in_ready=1, out_valid=0, Result=0, Overflow=CarryOut=Zero=0, hi=lo=0, state IDLE, counter 0.
- Single-cycle op, including MF/MT and illegal ops, accepted at edge t: out_valid=1 in the cycle after edge t (latency 1). Back-to-back accepts give an out_valid pulse every cycle.
- MT ops: hi/lo update at the same edge that sets out_valid.
- MULT/DIV accepted at edge t:
  - in_ready=0 for the cycles after edges t+1 … t+W+1.
  - hi/lo/Result update and out_valid=1 after edge t+W+2 (34 cycles for W=32).
  - in_ready=1 in that same cycle, so a new op may be accepted at edge t+W+3.
- MFHI/MFLO issued right after a mult/div returns the updated value; there is no hazard window.
- rst high at any edge, including mid-MUL/DIV: the op is aborted, all reset values are restored, and no out_valid is produced for the aborted op.
- out_valid has no backpressure. The consumer must capture it on the pulse.

## Configuration
- ALU_MDU_DIV_EN defined: the DIV/DIVU datapath and the DIV state are built as described.
- ALU_MDU_DIV_EN undefined: the divider and DIV state are removed. DIV/DIVU are treated as illegal opcodes: latency 1, Result = 0, flags 0, hi/lo unchanged.

## Test plan
- Reset: hold rst 2 cycles during an in-flight MULT → out_valid never pulses, hi=lo=0, in_ready=1 next cycle.
- ADD A=0x7FFFFFFF, B=1 → one cycle later Result=0x80000000, Overflow=1, CarryOut=0, Zero=0. SUB A=B=5 → Zero=1, CarryOut=1.
- SRA A=0x24 (shamt 4), B=0x80000000 → Result=0xF8000000. LUI B=0x1234ABCD → 0xABCD0000.
- MULT A=-3 (0xFFFFFFFD), B=7 → in_ready low 33 cycles, out_valid at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIV A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV A=0x80000000, B=-1 → lo=0x80000000, hi=0. DIVU A=9, B=0 → lo=0xFFFFFFFF, hi=9. Without ALU_MDU_DIV_EN: DIVU A=9, B=0 → Result=0 after 1 cycle, hi/lo unchanged.
- MTHI A=0x55; MFHI next cycle → Result=0x55. Illegal op 0x1F → Result=0, flags 0, out_valid after 1 cycle.

Source files
------------

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU with iterative multiply/divide into HI/LO
// Optional divider datapath: define ALU_MDU_DIV_EN.
module alu_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            ALUop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02, OP_SUB  = 5'h03;
    localparam logic [4:0] OP_SLT  = 5'h04, OP_SLTU = 5'h05, OP_SLL  = 5'h06, OP_SRL  = 5'h07;
    localparam logic [4:0] OP_SAL  = 5'h08, OP_SRA  = 5'h09, OP_LUI  = 5'h0A, OP_XOR  = 5'h0B;
    localparam logic [4:0] OP_NOR  = 5'h0C, OP_MULT = 5'h0D, OP_MULTU = 5'h0E, OP_DIV = 5'h0F;
    localparam logic [4:0] OP_DIVU = 5'h10, OP_MFHI = 5'h11, OP_MFLO = 5'h12, OP_MTHI = 5'h13;
    localparam logic [4:0] OP_MTLO = 5'h14;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_hi_q, acc_lo_q, opnd_q;
    logic          sa_q, sb_q, bz_q, is_div_q;
    logic [W-1:0]  result_q, hi_q, lo_q;
    logic          valid_q, ovf_q, cout_q, zero_q;

    logic               is_sub, is_mul, is_div, is_signed, a_neg, b_neg;
    logic [W-1:0]       b_eff, a_mag, b_mag, sc_res;
    logic [W:0]         sum;
    logic               sc_ovf, sc_cout, sc_zero;
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = A[SHAMT_W-1:0];
    assign is_sub = (ALUop == OP_SUB);
    assign b_eff  = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    assign is_mul = (ALUop == OP_MULT) || (ALUop == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
    assign is_div = (ALUop == OP_DIV) || (ALUop == OP_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign is_signed = (ALUop == OP_MULT) || (ALUop == OP_DIV);
    assign a_neg     = is_signed & A[W-1];
    assign b_neg     = is_signed & B[W-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // Opcodes not listed (illegal, and DIV/DIVU without the divider) yield zero.
    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_cout = 1'b0;
        sc_zero = 1'b0;
        case (ALUop)
            OP_AND:          sc_res = A & B;
            OP_OR:           sc_res = A | B;
            OP_ADD, OP_SUB: begin
                sc_res  = sum[W-1:0];
                sc_cout = sum[W];
                sc_ovf  = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_SLT:          sc_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:         sc_res = {{(W-1){1'b0}}, (A < B)};
            OP_SLL, OP_SAL:  sc_res = B << shamt;
            OP_SRL:          sc_res = B >> shamt;
            OP_SRA:          sc_res = $unsigned($signed(B) >>> shamt);
            OP_LUI:          sc_res = {B[HW-1:0], {HW{1'b0}}};
            OP_XOR:          sc_res = A ^ B;
            OP_NOR:          sc_res = ~(A | B);
            OP_MFHI:         sc_res = hi_q;
            OP_MFLO:         sc_res = lo_q;
            OP_MTHI, OP_MTLO: sc_res = A;
            default: ;
        endcase
        case (ALUop)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR: sc_zero = (sc_res == '0);
            default: ;
        endcase
    end

    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic [W:0]     mul_sum;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    assign quo_fix  = bz_q ? '1 : ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q);
    assign rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});

`ifdef ALU_MDU_DIV_EN
    logic [W:0] rem_sh, trial;
    assign rem_sh = {acc_hi_q, acc_lo_q[W-1]};
    assign trial  = rem_sh - {1'b0, opnd_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            is_div_q <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (in_valid) begin
                    if (is_mul || is_div) begin
                        state_q  <= is_mul ? S_MUL : S_DIV;
                        cnt_q    <= CW'(W);
                        acc_hi_q <= '0;
                        acc_lo_q <= is_mul ? b_mag : a_mag;
                        opnd_q   <= is_mul ? a_mag : b_mag;
                        sa_q     <= a_neg;
                        sb_q     <= b_neg;
                        bz_q     <= (B == '0);
                        is_div_q <= is_div;
                    end else begin
                        valid_q  <= 1'b1;
                        result_q <= sc_res;
                        ovf_q    <= sc_ovf;
                        cout_q   <= sc_cout;
                        zero_q   <= sc_zero;
                        if (ALUop == OP_MTHI) hi_q <= A;
                        if (ALUop == OP_MTLO) lo_q <= A;
                    end
                end
                // Shift-add: multiplier sits in acc_lo and drains out as product bits enter.
                S_MUL: if (cnt_q == '0) begin
                    state_q <= S_FIX;
                end else begin
                    acc_hi_q <= mul_sum[W:1];
                    acc_lo_q <= {mul_sum[0], acc_lo_q[W-1:1]};
                    cnt_q    <= cnt_q - CW'(1);
                end
`ifdef ALU_MDU_DIV_EN
                S_DIV: if (cnt_q == '0) begin
                    state_q <= S_FIX;
                end else begin
                    acc_hi_q <= trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
                    acc_lo_q <= {acc_lo_q[W-2:0], ~trial[W]};
                    cnt_q    <= cnt_q - CW'(1);
                end
`endif
                S_FIX: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b1;
                    ovf_q   <= 1'b0;
                    cout_q  <= 1'b0;
                    zero_q  <= 1'b0;
                    if (is_div_q) begin
                        hi_q     <= rem_fix;
                        lo_q     <= quo_fix;
                        result_q <= quo_fix;
                    end else begin
                        hi_q     <= prod_fix[2*W-1:W];
                        lo_q     <= prod_fix[W-1:0];
                        result_q <= prod_fix[W-1:0];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;
    assign Zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu (vector table, corner sequences, random vs model)
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02, OP_SUB  = 5'h03;
    localparam logic [4:0] OP_SLT  = 5'h04, OP_SLTU = 5'h05, OP_SLL  = 5'h06, OP_SRL  = 5'h07;
    localparam logic [4:0] OP_SAL  = 5'h08, OP_SRA  = 5'h09, OP_LUI  = 5'h0A, OP_XOR  = 5'h0B;
    localparam logic [4:0] OP_NOR  = 5'h0C, OP_MULT = 5'h0D, OP_MULTU = 5'h0E, OP_DIV = 5'h0F;
    localparam logic [4:0] OP_DIVU = 5'h10, OP_MFHI = 5'h11, OP_MFLO = 5'h12, OP_MTHI = 5'h13;
    localparam logic [4:0] OP_MTLO = 5'h14;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  ALUop = '0;
    logic        in_ready, out_valid, Overflow, CarryOut, Zero;
    logic [31:0] Result, hi, lo;

    always #5 clk = ~clk;

    alu_mdu #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .Result(Result),
        .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero), .hi(hi), .lo(lo)
    );

    int n_cmp = 0, n_fail = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; also advances the expected HI/LO.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic o, output logic c, output logic z,
                         output bit chk_r, output bit chk_oc, output int lat);
        longint sa, sb, sd;
        longint unsigned ua, ub, ud;
        logic [63:0] p;
        sa = $signed(a); sb = $signed(b); ua = {32'h0, a}; ub = {32'h0, b};
        r = '0; o = 1'b0; c = 1'b0; z = 1'b0; chk_r = 1'b1; chk_oc = 1'b1; lat = 0;
        case (op)
            OP_AND:  begin r = a & b; chk_oc = 1'b0; end
            OP_OR:   begin r = a | b; chk_oc = 1'b0; end
            OP_ADD:  begin sd = sa + sb; r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; o = (sd > SMAX) || (sd < SMIN); end
            OP_SUB:  begin sd = sa - sb; r = a - b; c = (ua >= ub); o = (sd > SMAX) || (sd < SMIN); end
            OP_SLT:  begin r = (sa < sb) ? 32'd1 : 32'd0; chk_oc = 1'b0; end
            OP_SLTU: begin r = (ua < ub) ? 32'd1 : 32'd0; chk_oc = 1'b0; end
            OP_SLL, OP_SAL: begin r = b << a[4:0]; chk_oc = 1'b0; end
            OP_SRL:  begin r = b >> a[4:0]; chk_oc = 1'b0; end
            OP_SRA:  begin sd = sb >>> a[4:0]; r = sd[31:0]; chk_oc = 1'b0; end
            OP_LUI:  begin r = b * 32'h0001_0000; chk_oc = 1'b0; end
            OP_XOR:  begin r = a ^ b; chk_oc = 1'b0; end
            OP_NOR:  begin r = ~(a | b); chk_oc = 1'b0; end
            OP_MULT: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; r = exp_lo; lat = W + 2; end
            OP_MULTU: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; r = exp_lo; lat = W + 2; end
`ifdef ALU_MDU_DIV_EN
            OP_DIV: begin
                lat = W + 2;
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else begin sd = sa / sb; exp_lo = sd[31:0]; sd = sa % sb; exp_hi = sd[31:0]; end
                r = exp_lo;
            end
            OP_DIVU: begin
                lat = W + 2;
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else begin ud = ua / ub; exp_lo = ud[31:0]; ud = ua % ub; exp_hi = ud[31:0]; end
                r = exp_lo;
            end
`endif
            OP_MFHI: r = exp_hi;
            OP_MFLO: r = exp_lo;
            OP_MTHI: begin exp_hi = a; chk_r = 1'b0; end
            OP_MTLO: begin exp_lo = a; chk_r = 1'b0; end
            default: r = '0;
        endcase
        if (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR}) z = (r == 0);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic eo, ec, ez;
        bit cr, coc;
        int lat, k, rdy_low;
        model(op, a, b, er, eo, ec, ez, cr, coc, lat);
        @(negedge clk);
        ALUop = op; A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0; rdy_low = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
            if (k <= W + 1 && !in_ready) rdy_low++;
        end
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " latency"}, k, lat);
        chk({tag, " in_ready low cycles"}, rdy_low, (lat == 0) ? 0 : W + 1);
        chk({tag, " in_ready at done"}, in_ready, 1);
        if (cr) chk({tag, " Result"}, Result, er);
        chk({tag, " Zero"}, Zero, ez);
        if (coc) begin
            chk({tag, " Overflow"}, Overflow, eo);
            chk({tag, " CarryOut"}, CarryOut, ec);
        end
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        chk({tag, " pulse end"}, out_valid, 0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom();
            1: v = $urandom_range(0, 20);
            2: begin v = $urandom_range(1, 20); v = -v; end
            default: case ($urandom_range(0, 4))
                0: v = 32'h0;
                1: v = 32'h1;
                2: v = 32'hFFFF_FFFF;
                3: v = 32'h8000_0000;
                default: v = 32'h7FFF_FFFF;
            endcase
        endcase
        return v;
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic        ovf, cout, zero;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        int k, pulses;
        vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{OP_SRA,  32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_LUI,  32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5'h1F,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_AND,  32'hFF00_FF00, 32'h00FF_00FF, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{OP_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_SLL,  32'h0000_0021, 32'h8000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_SAL,  32'h0000_003F, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_XOR,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{5'h15,   32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset Result", Result, 0);
        chk("reset flags", {Overflow, CarryOut, Zero}, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        rst = 1'b0;

        // Back-to-back single-cycle ops: one result per cycle.
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("vec%0d out_valid", i - 1), out_valid, 1);
                chk($sformatf("vec%0d Result", i - 1), Result, vecs[i-1].res);
                chk($sformatf("vec%0d Zero", i - 1), Zero, vecs[i-1].zero);
                if (vecs[i-1].op inside {OP_ADD, OP_SUB} || vecs[i-1].op >= 5'h15) begin
                    chk($sformatf("vec%0d Overflow", i - 1), Overflow, vecs[i-1].ovf);
                    chk($sformatf("vec%0d CarryOut", i - 1), CarryOut, vecs[i-1].cout);
                end
            end
            if (i < NV) begin
                ALUop = vecs[i].op; A = vecs[i].a; B = vecs[i].b; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFEB);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("multu hi const", hi, 32'h0000_0006);
        chk("multu lo const", lo, 32'hFFFF_FFEB);
`ifdef ALU_MDU_DIV_EN
        run_op("div neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div neg lo const", lo, 32'hFFFF_FFFD);
        chk("div neg hi const", hi, 32'hFFFF_FFFF);
        run_op("div min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div min lo const", lo, 32'h8000_0000);
        chk("div min hi const", hi, 32'h0000_0000);
        run_op("divu zero", OP_DIVU, 32'h0000_0009, 32'h0000_0000);
        chk("divu zero lo const", lo, 32'hFFFF_FFFF);
        chk("divu zero hi const", hi, 32'h0000_0009);
`else
        run_op("divu off", OP_DIVU, 32'h0000_0009, 32'h0000_0000);
        chk("divu off Result const", Result, 32'h0);
        chk("divu off hi const", hi, 32'h0000_0006);
`endif

        // MFLO held on in_valid while busy: must be taken only after the MULTU returns.
        @(negedge clk);
        ALUop = OP_MULTU; A = 32'h3; B = 32'h5; in_valid = 1'b1;
        @(negedge clk);
        ALUop = OP_MFLO; A = '0; B = '0;
        k = 0;
        while (!out_valid && k < 60) begin @(negedge clk); k++; end
        chk("held mult latency", k, W + 2);
        chk("held mult lo", lo, 32'd15);
        chk("held mult hi", hi, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mflo after mult valid", out_valid, 1);
        chk("mflo after mult Result", Result, 32'd15);
        @(negedge clk);
        chk("mflo single pulse", out_valid, 0);
        exp_hi = 32'd0; exp_lo = 32'd15;

        @(negedge clk);
        ALUop = OP_MTHI; A = 32'h55; in_valid = 1'b1;
        @(negedge clk);
        chk("mthi valid", out_valid, 1);
        chk("mthi hi", hi, 32'h55);
        chk("mthi flags", {Overflow, CarryOut, Zero}, 0);
        ALUop = OP_MFHI; A = '0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mfhi valid", out_valid, 1);
        chk("mfhi Result", Result, 32'h55);
        exp_hi = 32'h55;

        run_op("illegal 1f", 5'h1F, 32'h1234_5678, 32'h9ABC_DEF0);

        // Reset in the middle of a MULT aborts it without a result pulse.
        @(negedge clk);
        ALUop = OP_MULT; A = 32'hFFFF_FFFD; B = 32'h7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pulses = 0;
        repeat (5) begin @(negedge clk); if (out_valid) pulses++; end
        rst = 1'b1;
        repeat (2) begin @(negedge clk); if (out_valid) pulses++; end
        rst = 1'b0;
        chk("abort in_ready", in_ready, 1);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        chk("abort Result", Result, 0);
        exp_hi = '0; exp_lo = '0;
        for (int i = 0; i < 45; i++) begin @(negedge clk); if (out_valid) pulses++; end
        chk("abort no out_valid", pulses, 0);

        for (int n = 0; n < 250; n++) begin
            int s;
            logic [4:0] op;
            s = $urandom_range(0, 99);
            if (s < 65)      op = 5'($urandom_range(0, 12));
            else if (s < 82) op = 5'($urandom_range(13, 16));
            else if (s < 94) op = 5'($urandom_range(17, 20));
            else             op = 5'($urandom_range(21, 31));
            run_op($sformatf("rand%0d op%0h", n, op), op, pick(), pick());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
